// File: rtl/first_pkg.sv
// Shared constants and helpers for the first_unit tick generator.
package first_pkg;

   localparam int unsigned FIRST_DEFAULT_WIDTH = 4;

   // Default terminal is the all-ones value for the given width (saturates at 32 bits).
   function automatic int unsigned first_default_terminal(input int unsigned width);
      if (width >= 32) return 32'hFFFF_FFFF;
      return (32'd1 << width) - 32'd1;
   endfunction

endpackage

// File: rtl/first_if.sv
// Enable/clear inputs and terminal-count pulse output of the tick generator.
interface first_if;
   logic a;
   logic b;
   logic out;

   modport master (output a, output b, input out);
   modport slave  (input a, input b, output out);
endinterface

// File: rtl/first_cnt.sv
// Enable/clear counter that wraps at TERMINAL; wrap is combinational on the wrapping edge.
module first_cnt
   import first_pkg::*;
#(
   parameter int unsigned WIDTH    = FIRST_DEFAULT_WIDTH,
   parameter int unsigned TERMINAL = first_default_terminal(WIDTH)
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic wrap
);

   localparam logic [WIDTH-1:0] TERM = WIDTH'(TERMINAL);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   // Clear beats enable; exact-equality compare keeps cnt within 0..TERMINAL.
   always_comb begin
      cnt_d = cnt_q;
      wrap  = 1'b0;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         if (cnt_q == TERM) begin
            cnt_d = '0;
            wrap  = 1'b1;
         end else begin
            cnt_d = cnt_q + WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/first_unit.sv
// Periodic tick generator: counts enabled cycles and emits a registered one-cycle pulse on wrap.
module first_unit
   import first_pkg::*;
#(
   parameter int unsigned WIDTH    = FIRST_DEFAULT_WIDTH,
   parameter int unsigned TERMINAL = first_default_terminal(WIDTH)
) (
   input logic    clk,
   input logic    rst,
   first_if.slave bus
);

   logic wrap;
   logic out_q;
   logic out_d;

   first_cnt #(
      .WIDTH    (WIDTH),
      .TERMINAL (TERMINAL)
   ) u_cnt (
      .clk  (clk),
      .rst  (rst),
      .en   (bus.a),
      .clr  (bus.b),
      .wrap (wrap)
   );

   always_comb begin
      out_d = wrap;
   end

   // out comes straight from this flop, so a/b never reach it combinationally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) out_q <= 1'b0;
      else     out_q <= out_d;
   end

   assign bus.out = out_q;

endmodule

// File: tb/tb_first_unit.sv
// Directed bench for first_unit: reset, free run, clear priority, pause, async reset at wrap, terminal corners.
module tb_first_unit;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   first_if if0   ();
   first_if if_t0 ();
   first_if if_t3 ();

   first_unit u0 (
      .clk (clk),
      .rst (rst),
      .bus (if0)
   );

   first_unit #(.WIDTH(4), .TERMINAL(0)) u_t0 (
      .clk (clk),
      .rst (rst),
      .bus (if_t0)
   );

   first_unit #(.WIDTH(4), .TERMINAL(3)) u_t3 (
      .clk (clk),
      .rst (rst),
      .bus (if_t3)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] cnt0();
      return 32'(u0.u_cnt.cnt_q);
   endfunction

   initial begin
      rst     = 1'b1;
      if0.a   = 1'b0;  if0.b   = 1'b0;
      if_t0.a = 1'b0;  if_t0.b = 1'b0;
      if_t3.a = 1'b0;  if_t3.b = 1'b0;
      tick();
      tick();
      chk("reset_out", 32'(if0.out), 32'd0);
      chk("reset_cnt", cnt0(), 32'd0);

      // Free run: pulse visible after edges 16, 32, 48 only.
      rst   = 1'b0;
      if0.a = 1'b1;
      for (int k = 1; k <= 48; k++) begin
         tick();
         chk("free_run_out", 32'(if0.out), 32'(k % 16 == 0));
         if (k == 7) chk("free_run_cnt7", cnt0(), 32'd7);
      end

      // Async reset while out is high, without a clock edge; X inputs during reset.
      #4;
      rst   = 1'b1;
      if0.a = 1'bx;
      if0.b = 1'bx;
      #1;
      chk("async_rst_out", 32'(if0.out), 32'd0);
      chk("async_rst_cnt", cnt0(), 32'd0);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("rst_hold_out", 32'(if0.out), 32'd0);
         chk("rst_hold_cnt", cnt0(), 32'd0);
      end

      // Clear priority at cnt == TERMINAL.
      if0.a = 1'b1;
      if0.b = 1'b0;
      rst   = 1'b0;
      for (int k = 1; k <= 15; k++) begin
         tick();
         chk("pre_clr_out", 32'(if0.out), 32'd0);
      end
      chk("pre_clr_cnt", cnt0(), 32'd15);
      if0.b = 1'b1;
      tick();
      chk("clr_prio_out", 32'(if0.out), 32'd0);
      chk("clr_prio_cnt", cnt0(), 32'd0);
      if0.b = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         tick();
         chk("post_clr_out", 32'(if0.out), 32'(k == 16));
      end

      // Pause: 10 enabled, 5 frozen, then 6 more to the pulse.
      for (int k = 1; k <= 10; k++) begin
         tick();
         chk("pause_run_out", 32'(if0.out), 32'd0);
      end
      if0.a = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         tick();
         chk("pause_hold_out", 32'(if0.out), 32'd0);
      end
      chk("pause_hold_cnt", cnt0(), 32'd10);
      if0.a = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         tick();
         chk("resume_out", 32'(if0.out), 32'(k == 6));
      end
      tick();
      chk("no_double_out", 32'(if0.out), 32'd0);

      // Async reset in the cycle where cnt == TERMINAL with a=1: pulse is lost.
      for (int k = 1; k <= 14; k++) begin
         tick();
         chk("pre_wrap_out", 32'(if0.out), 32'd0);
      end
      chk("pre_wrap_cnt", cnt0(), 32'd15);
      #4;
      rst = 1'b1;
      #1;
      chk("wrap_rst_out", 32'(if0.out), 32'd0);
      chk("wrap_rst_cnt", cnt0(), 32'd0);
      tick();
      chk("wrap_rst_edge_out", 32'(if0.out), 32'd0);
      rst = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         tick();
         chk("post_wrap_rst_out", 32'(if0.out), 32'(k == 16));
      end

      // Terminal corners: TERMINAL=0 holds high, TERMINAL=3 pulses every 4th edge.
      rst   = 1'b1;
      if0.a = 1'b0;
      tick();
      chk("t0_idle_out", 32'(if_t0.out), 32'd0);
      chk("t3_idle_out", 32'(if_t3.out), 32'd0);
      rst     = 1'b0;
      if_t0.a = 1'b1;
      if_t3.a = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         tick();
         chk("t0_out", 32'(if_t0.out), 32'd1);
         chk("t3_out", 32'(if_t3.out), 32'(k % 4 == 0));
      end
      if_t0.b = 1'b1;
      tick();
      chk("t0_clr_out", 32'(if_t0.out), 32'd0);
      if_t0.b = 1'b0;
      tick();
      chk("t0_resume_out", 32'(if_t0.out), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
